// File: rtl/case6_pkg.sv
// Shared definitions for the case6 result packer: FSM states, word layout,
// drop counter width and the word-assembly helper.
package case6_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HALF  = 1'b1
    } pack_state_e;

    localparam int SAMPLE_W   = 3;
    localparam int WORD_W     = 8;
    localparam int PAIR_BIT   = 7;
    localparam int ZERO_BIT   = 6;
    localparam int S1_LSB     = 3;
    localparam int S0_LSB     = 0;
    localparam logic PAIR_FLAG = 1'b1;
    localparam int DROP_CNT_W = 8;

    // Bit 6 is reserved and always packed as zero.
    function automatic logic [WORD_W-1:0] pack_word(input logic pair,
                                                    input logic [SAMPLE_W-1:0] s1,
                                                    input logic [SAMPLE_W-1:0] s0);
        logic [WORD_W-1:0] w;
        w                      = '0;
        w[PAIR_BIT]            = pair;
        w[ZERO_BIT]            = 1'b0;
        w[S1_LSB +: SAMPLE_W]  = s1;
        w[S0_LSB +: SAMPLE_W]  = s0;
        return w;
    endfunction

endpackage

// File: rtl/case6_sync_fifo.sv
// Flop-based synchronous FIFO; a push at full is accepted when a pop happens
// in the same cycle. Read data reads as zero while empty.
module case6_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [AW-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]               count_q, count_d;
    logic                        do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);
    assign count = count_q;
    assign rdata = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/case6_result_packer.sv
// Packs 3-bit case6 samples two per byte into an output FIFO, with flush of a
// half word, sticky overflow and a saturating dropped-sample counter.
module case6_result_packer
    import case6_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic                  y1,
    input  logic                  y2,
    input  logic                  y3,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_W-1:0]     out_data,
    output logic                  overflow,
    output logic [DROP_CNT_W-1:0] drop_cnt
);
    pack_state_e             state_q, state_d;
    logic [SAMPLE_W-1:0]     held_q, held_d;
    logic                    overflow_q, overflow_d;
    logic [DROP_CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

    logic [SAMPLE_W-1:0]     sample;
    logic                    push_req, pop_fire, drop;
    logic [WORD_W-1:0]       push_word;
    logic [1:0]              push_n;
    logic [DROP_CNT_W:0]     drop_sum;
    logic                    fifo_full, fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                    fifo_cnt_unused;

    assign sample          = {y3, y2, y1};
    assign pop_fire        = out_ready && !fifo_empty;
    assign out_valid       = !fifo_empty;
    assign overflow        = overflow_q;
    assign drop_cnt        = drop_cnt_q;
    assign fifo_cnt_unused = ^fifo_count;

    always_comb begin
        state_d   = state_q;
        held_d    = held_q;
        push_req  = 1'b0;
        push_word = '0;
        push_n    = 2'd0;
        case (state_q)
            ST_EMPTY: begin
                if (in_valid && flush) begin
                    push_req  = 1'b1;
                    push_word = pack_word(1'b0, 3'b000, sample);
                    push_n    = 2'd1;
                end else if (in_valid) begin
                    held_d  = sample;
                    state_d = ST_HALF;
                end
            end
            ST_HALF: begin
                // A completing sample wins over a same-cycle flush.
                if (in_valid) begin
                    push_req  = 1'b1;
                    push_word = pack_word(PAIR_FLAG, sample, held_q);
                    push_n    = 2'd2;
                    held_d    = '0;
                    state_d   = ST_EMPTY;
                end else if (flush) begin
                    push_req  = 1'b1;
                    push_word = pack_word(1'b0, 3'b000, held_q);
                    push_n    = 2'd1;
                    held_d    = '0;
                    state_d   = ST_EMPTY;
                end
            end
        endcase

        drop       = push_req && fifo_full && !pop_fire;
        overflow_d = overflow_q || drop;
        drop_sum   = {1'b0, drop_cnt_q} + (DROP_CNT_W+1)'(push_n);
        drop_cnt_d = drop_cnt_q;
        if (drop) drop_cnt_d = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            held_q     <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            held_q     <= held_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    case6_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_req),
        .wdata (push_word),
        .pop   (out_ready),
        .rdata (out_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_case6_result_packer.sv
// Bench for case6_result_packer: directed table, corner sequences and random
// traffic checked against a queue-based reference model.
module tb_case6_result_packer;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, y1, y2, y3, flush, out_ready;
    logic       out_valid, overflow;
    logic [7:0] out_data, drop_cnt;

    int n_vec = 0;
    int n_bad = 0;

    // reference model
    bit         m_half;
    logic [2:0] m_held;
    logic [7:0] mq[$];
    bit         m_ovf;
    int         m_dc;

    typedef struct {
        logic       iv;
        logic [2:0] s;
        logic       fl;
        logic       rdy;
        logic       eov;
        logic [7:0] eod;
    } vec_t;
    vec_t tbl[12];

    always #5 clk = ~clk;

    case6_result_packer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .y1        (y1),
        .y2        (y2),
        .y3        (y3),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_half = 0;
        m_held = 3'b000;
        mq.delete();
        m_ovf  = 0;
        m_dc   = 0;
    endtask

    task automatic model_step(input logic iv, input logic [2:0] s, input logic fl, input logic rdy);
        bit         have;
        logic [7:0] w;
        int         n;
        have = 0; w = 8'h00; n = 0;
        if (m_half) begin
            if (iv) begin
                w = {1'b1, 1'b0, s, m_held}; n = 2; have = 1; m_half = 0;
            end else if (fl) begin
                w = {5'b00000, m_held}; n = 1; have = 1; m_half = 0;
            end
        end else if (iv) begin
            if (fl) begin
                w = {5'b00000, s}; n = 1; have = 1;
            end else begin
                m_held = s; m_half = 1;
            end
        end
        if (rdy && mq.size() > 0) void'(mq.pop_front());
        if (have) begin
            if (mq.size() < DEPTH) mq.push_back(w);
            else begin
                m_ovf = 1;
                m_dc  = (m_dc + n > 255) ? 255 : m_dc + n;
            end
        end
    endtask

    task automatic compare_model();
        chk("out_valid", out_valid, mq.size() > 0);
        chk("out_data", out_data, (mq.size() > 0) ? mq[0] : 8'h00);
        chk("overflow", overflow, m_ovf);
        chk("drop_cnt", drop_cnt, m_dc);
    endtask

    task automatic step(input logic iv, input logic [2:0] s, input logic fl, input logic rdy);
        in_valid = iv; {y3, y2, y1} = s; flush = fl; out_ready = rdy;
        @(posedge clk);
        if (rst_n) model_step(iv, s, fl, rdy);
        #1;
        compare_model();
    endtask

    initial begin
        logic [2:0] smp[10];
        logic [7:0] first;
        logic [2:0] a, b;
        int         nw;

        tbl[0]  = '{1'b1, 3'b101, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[1]  = '{1'b1, 3'b010, 1'b0, 1'b1, 1'b1, 8'h95};
        tbl[2]  = '{1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[3]  = '{1'b1, 3'b111, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[4]  = '{1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[5]  = '{1'b0, 3'b000, 1'b1, 1'b1, 1'b1, 8'h07};
        tbl[6]  = '{1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[7]  = '{1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[8]  = '{1'b1, 3'b011, 1'b1, 1'b1, 1'b1, 8'h03};
        tbl[9]  = '{1'b1, 3'b001, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[10] = '{1'b1, 3'b110, 1'b0, 1'b1, 1'b1, 8'hB1};
        tbl[11] = '{1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 8'h00};

        rst_n = 1'b0; in_valid = 0; {y3, y2, y1} = 3'b000; flush = 0; out_ready = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_drop_cnt", drop_cnt, 8'h00);
        #3 rst_n = 1'b1;

        // directed table: pair, flush of half word, flush with sample in EMPTY
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].iv, tbl[i].s, tbl[i].fl, tbl[i].rdy);
            chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].eov);
            chk($sformatf("tbl%0d_data", i), out_data, tbl[i].eod);
        end

        // backpressure: 10 samples, 5 pair words, the 5th is dropped
        for (int i = 0; i < 10; i++) smp[i] = 3'($urandom_range(0, 7));
        first = {2'b10, smp[1], smp[0]};
        for (int i = 0; i < 10; i++) begin
            step(1'b1, smp[i], 1'b0, 1'b0);
            if (i >= 1) chk("hold_data", out_data, first);
        end
        chk("bp_overflow", overflow, 1'b1);
        chk("bp_drop_cnt", drop_cnt, 8'd2);

        // full FIFO: completing sample with simultaneous pop is accepted
        a = 3'b100; b = 3'b011;
        step(1'b1, a, 1'b0, 1'b0);
        step(1'b1, b, 1'b0, 1'b1);
        chk("full_pp_drop_cnt", drop_cnt, 8'd2);
        nw = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) nw++;
            step(1'b0, 3'b000, 1'b0, 1'b1);
        end
        chk("full_pp_words", nw, 4);

        // reset mid-operation: HALF with two words buffered
        for (int i = 0; i < 5; i++) step(1'b1, 3'($urandom_range(0, 7)), 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_drop_cnt", drop_cnt, 8'h00);
        chk("midrst_overflow", overflow, 1'b0);
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        step(1'b0, 3'b000, 1'b1, 1'b1);
        chk("post_rst_flush", out_valid, 1'b0);
        step(1'b0, 3'b000, 1'b0, 1'b1);

        // random traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) < 7));

        // drop counter saturation
        for (int i = 0; i < 330; i++) step(1'b1, 3'($urandom_range(0, 7)), 1'b0, 1'b0);
        chk("sat_drop_cnt", drop_cnt, 8'd255);
        for (int i = 0; i < 8; i++) step(1'b0, 3'b000, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
